// File: rtl/fsm_start_sequencer.sv
// fsm_start_sequencer
//   Initiator side of a three-state IDLE/INIT/STRT control FSM. On a start
//   request it resets the controlled FSM, confirms it sits in IDLE, enables
//   it, and waits a bounded time for STRT. A failed attempt is retried up to
//   MAX_RETRY times. An illegal state code, or a backward step of the
//   controlled FSM, aborts the sequence at once without retrying.
//
// Ports
//   clock_i        system clock, rising edge
//   reset_i        synchronous active-high reset
//   start_i        start request, sampled only while not busy
//   abort_i        abandon the current sequence and return to idle
//   state_i        one-hot state of the controlled FSM
//   fsm_reset_o    reset input of the controlled FSM
//   fsm_enable_o   enable input of the controlled FSM
//   busy_o         sequence in progress (reset, check or run phase)
//   done_o         controlled FSM reached STRT
//   fail_o         retries exhausted or illegal behaviour seen
//   illegal_o      sticky illegal state / illegal transition flag
//   retry_count_o  failed attempts in the current sequence
module fsm_start_sequencer #(
    parameter int unsigned     SIZE       = 3,
    parameter logic [SIZE-1:0] IDLE       = 3'b001,
    parameter logic [SIZE-1:0] INIT       = 3'b010,
    parameter logic [SIZE-1:0] STRT       = 3'b100,
    parameter int unsigned     RST_CYCLES = 2,
    parameter int unsigned     TIMEOUT    = 8,
    parameter int unsigned     MAX_RETRY  = 3
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [SIZE-1:0] state_i,
    output logic            fsm_reset_o,
    output logic            fsm_enable_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            fail_o,
    output logic            illegal_o,
    output logic [3:0]      retry_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_CHECK, S_RUN, S_DONE, S_FAIL
    } state_t;

    state_t          state, state_next;
    logic [3:0]      rst_cnt, rst_cnt_next;
    logic [7:0]      timer, timer_next, timer_inc;
    logic [3:0]      retry_next;
    logic [SIZE-1:0] prev, prev_next;
    logic            fsm_reset_next, fsm_enable_next, busy_next;
    logic            done_next, fail_next, illegal_next;
    logic            monitor, bad_code, backward, illegal_hit, attempt_fail;

    // Progress order of the controlled FSM; used to spot backward steps.
    function automatic logic [1:0] rank(input logic [SIZE-1:0] code);
        if (code == STRT) return 2'd2;
        if (code == INIT) return 2'd1;
        return 2'd0;
    endfunction

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state         <= S_IDLE;
            rst_cnt       <= '0;
            timer         <= '0;
            prev          <= IDLE;
            fsm_reset_o   <= 1'b0;
            fsm_enable_o  <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            fail_o        <= 1'b0;
            illegal_o     <= 1'b0;
            retry_count_o <= '0;
        end else begin
            state         <= state_next;
            rst_cnt       <= rst_cnt_next;
            timer         <= timer_next;
            prev          <= prev_next;
            fsm_reset_o   <= fsm_reset_next;
            fsm_enable_o  <= fsm_enable_next;
            busy_o        <= busy_next;
            done_o        <= done_next;
            fail_o        <= fail_next;
            illegal_o     <= illegal_next;
            retry_count_o <= retry_next;
        end
    end

    always_comb begin
        state_next      = state;
        rst_cnt_next    = rst_cnt;
        timer_next      = timer;
        retry_next      = retry_count_o;
        fsm_reset_next  = 1'b0;
        fsm_enable_next = fsm_enable_o;
        done_next       = done_o;
        fail_next       = fail_o;
        illegal_next    = illegal_o;
        attempt_fail    = 1'b0;
        timer_inc       = timer + 8'd1;

        // While the controlled FSM is held in reset its history is
        // meaningless, so the comparison baseline restarts at IDLE.
        prev_next = fsm_reset_o ? IDLE : state_i;

        monitor     = (state == S_CHECK) || (state == S_RUN) || (state == S_DONE);
        bad_code    = (state_i != IDLE) && (state_i != INIT) && (state_i != STRT);
        backward    = !bad_code && (rank(state_i) < rank(prev));
        illegal_hit = monitor && (bad_code || backward);

        if (abort_i) begin
            // Abort also swallows a start request on the same edge.
            if (state != S_IDLE) begin
                state_next      = S_IDLE;
                fsm_reset_next  = 1'b1;
                fsm_enable_next = 1'b0;
                done_next       = 1'b0;
            end
        end else if (illegal_hit) begin
            state_next      = S_FAIL;
            fsm_enable_next = 1'b0;
            done_next       = 1'b0;
            fail_next       = 1'b1;
            illegal_next    = 1'b1;
        end else begin
            case (state)
                S_RESET: begin
                    if (rst_cnt <= 4'd1) begin
                        state_next = S_CHECK;
                    end else begin
                        rst_cnt_next   = rst_cnt - 4'd1;
                        fsm_reset_next = 1'b1;
                    end
                end
                S_CHECK: begin
                    if (state_i == IDLE) begin
                        state_next      = S_RUN;
                        fsm_enable_next = 1'b1;
                        timer_next      = '0;
                    end else begin
                        attempt_fail = 1'b1;
                    end
                end
                S_RUN: begin
                    timer_next = timer_inc;
                    // STRT on the timeout edge still counts as success.
                    if (state_i == STRT) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end else if (timer_inc == 8'(TIMEOUT)) begin
                        attempt_fail = 1'b1;
                    end
                end
                default: begin
                    if (start_i) begin
                        state_next      = S_RESET;
                        rst_cnt_next    = 4'(RST_CYCLES);
                        fsm_reset_next  = 1'b1;
                        fsm_enable_next = 1'b0;
                        done_next       = 1'b0;
                        fail_next       = 1'b0;
                        illegal_next    = 1'b0;
                        retry_next      = '0;
                    end
                end
            endcase
        end

        if (attempt_fail) begin
            fsm_enable_next = 1'b0;
            if (retry_count_o < 4'(MAX_RETRY)) begin
                retry_next     = retry_count_o + 4'd1;
                state_next     = S_RESET;
                rst_cnt_next   = 4'(RST_CYCLES);
                fsm_reset_next = 1'b1;
            end else begin
                state_next = S_FAIL;
                fail_next  = 1'b1;
            end
        end

        busy_next = (state_next == S_RESET) || (state_next == S_CHECK) ||
                    (state_next == S_RUN);
    end

endmodule

// File: tb/tb_fsm_start_sequencer.sv
// Bench for fsm_start_sequencer: a controlled IDLE/INIT/STRT FSM is attached
// to the DUT, with knobs to make it stick in INIT or to override its state.
// A timeline-based reference model (attempt number + cycles into attempt)
// predicts every output each cycle; directed scenarios add literal checks.
module tb_fsm_start_sequencer;

    localparam logic [2:0] IDLE_C = 3'b001;
    localparam logic [2:0] INIT_C = 3'b010;
    localparam logic [2:0] STRT_C = 3'b100;
    localparam int RST  = 2;
    localparam int TMO  = 8;
    localparam int MAXR = 3;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [2:0] state_i;
    logic       fsm_reset_o, fsm_enable_o, busy_o, done_o, fail_o, illegal_o;
    logic [3:0] retry_count_o;

    int checks = 0;
    int errors = 0;

    // controlled FSM and fault knobs
    logic [2:0] fsm_state = IDLE_C;
    bit         stuck = 1'b0;
    bit         force_en = 1'b0;
    logic [2:0] force_val = 3'b000;

    assign state_i = force_en ? force_val : fsm_state;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_i || fsm_reset_o) fsm_state <= IDLE_C;
        else if (fsm_enable_o) begin
            if (fsm_state == IDLE_C) fsm_state <= INIT_C;
            else if (fsm_state == INIT_C && !stuck) fsm_state <= STRT_C;
        end
    end

    fsm_start_sequencer #(
        .SIZE(3), .IDLE(IDLE_C), .INIT(INIT_C), .STRT(STRT_C),
        .RST_CYCLES(RST), .TIMEOUT(TMO), .MAX_RETRY(MAXR)
    ) dut (
        .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
        .state_i(state_i), .fsm_reset_o(fsm_reset_o), .fsm_enable_o(fsm_enable_o),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .illegal_o(illegal_o),
        .retry_count_o(retry_count_o)
    );

    // ---------------- reference model ----------------
    bit         m_active, m_in_done, m_in_fail, m_fail, m_ill, m_pulse;
    int         m_t, m_attempt;
    logic [2:0] m_prev;

    function automatic int rank(input logic [2:0] v);
        if (v == IDLE_C) return 0;
        if (v == INIT_C) return 1;
        if (v == STRT_C) return 2;
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_in_done = 0; m_in_fail = 0; m_fail = 0; m_ill = 0;
        m_pulse = 0; m_t = 0; m_attempt = 0; m_prev = IDLE_C;
    endtask

    task automatic model_step(input bit st, input bit ab, input logic [2:0] sv);
        bit rst_before, mon, bad, failed;
        rst_before = (m_active && m_t < RST) || m_pulse;
        mon = (m_active && m_t >= RST) || m_in_done;
        bad = (rank(sv) < 0) || (rank(sv) < rank(m_prev));
        failed = 0;
        m_pulse = 0;
        if (ab) begin
            if (m_active || m_in_done || m_in_fail) begin
                m_active = 0; m_in_done = 0; m_in_fail = 0; m_pulse = 1;
            end
        end else if (mon && bad) begin
            m_active = 0; m_in_done = 0; m_in_fail = 1; m_fail = 1; m_ill = 1;
        end else if (m_active) begin
            if (m_t < RST) m_t++;
            else if (m_t == RST) begin
                if (sv == IDLE_C) m_t++; else failed = 1;
            end else if (sv == STRT_C) begin
                m_active = 0; m_in_done = 1;
            end else if (m_t - RST == TMO) failed = 1;
            else m_t++;
        end else if (st) begin
            m_active = 1; m_t = 0; m_attempt = 0; m_in_done = 0; m_in_fail = 0;
            m_fail = 0; m_ill = 0;
        end
        if (failed) begin
            if (m_attempt < MAXR) begin m_attempt++; m_t = 0; end
            else begin m_active = 0; m_in_fail = 1; m_fail = 1; end
        end
        m_prev = rst_before ? IDLE_C : sv;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 60)
                $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("busy", 8'(busy_o), 8'(m_active));
        chk("fsm_reset", 8'(fsm_reset_o), 8'((m_active && m_t < RST) || m_pulse));
        chk("fsm_enable", 8'(fsm_enable_o), 8'((m_active && m_t > RST) || m_in_done));
        chk("done", 8'(done_o), 8'(m_in_done));
        chk("fail", 8'(fail_o), 8'(m_fail));
        chk("illegal", 8'(illegal_o), 8'(m_ill));
        chk("retry", 8'(retry_count_o), 8'(m_attempt));
    endtask

    // One clock: check current outputs, apply inputs, advance model, wait.
    task automatic tick(input bit st, input bit ab);
        logic [2:0] sv;
        compare_model();
        start_i = st;
        abort_i = ab;
        sv = force_en ? force_val : fsm_state;
        model_step(st, ab, sv);
        @(negedge clk);
    endtask

    initial begin
        // reset
        repeat (2) @(negedge clk);
        chk("rst_busy", 8'(busy_o), 8'd0);
        chk("rst_fsm_reset", 8'(fsm_reset_o), 8'd0);
        chk("rst_enable", 8'(fsm_enable_o), 8'd0);
        chk("rst_done", 8'(done_o), 8'd0);
        chk("rst_fail", 8'(fail_o), 8'd0);
        chk("rst_illegal", 8'(illegal_o), 8'd0);
        chk("rst_retry", 8'(retry_count_o), 8'd0);
        reset_i = 1'b0;
        model_reset();
        tick(0, 0);

        // nominal run
        tick(1, 0);                               // e0
        chk("nom_rst_e0", 8'(fsm_reset_o), 8'd1);
        tick(0, 0);                               // e1
        chk("nom_rst_e1", 8'(fsm_reset_o), 8'd1);
        tick(0, 0);                               // e2
        chk("nom_rst_e2", 8'(fsm_reset_o), 8'd0);
        chk("nom_en_e2", 8'(fsm_enable_o), 8'd0);
        tick(0, 0);                               // e3
        chk("nom_en_e3", 8'(fsm_enable_o), 8'd1);
        tick(0, 0); tick(0, 0);                   // e4, e5
        chk("nom_done_e5", 8'(done_o), 8'd0);
        tick(0, 0);                               // e6
        chk("nom_done_e6", 8'(done_o), 8'd1);
        chk("nom_busy_e6", 8'(busy_o), 8'd0);
        chk("nom_retry", 8'(retry_count_o), 8'd0);
        tick(0, 0);

        // stuck in INIT for every attempt
        stuck = 1;
        tick(1, 0);
        for (int k = 1; k <= 44; k++) begin
            tick(0, 0);
            if (k == 11) chk("stk_retry_e11", 8'(retry_count_o), 8'd1);
            if (k == 22) chk("stk_retry_e22", 8'(retry_count_o), 8'd2);
            if (k == 43) chk("stk_fail_e43", 8'(fail_o), 8'd0);
        end
        chk("stk_fail", 8'(fail_o), 8'd1);
        chk("stk_retry", 8'(retry_count_o), 8'd3);
        chk("stk_illegal", 8'(illegal_o), 8'd0);
        chk("stk_enable", 8'(fsm_enable_o), 8'd0);

        // stuck on first attempt only
        tick(1, 0);
        for (int k = 1; k <= 11; k++) tick(0, 0);
        stuck = 0;
        for (int k = 12; k <= 17; k++) tick(0, 0);
        chk("rec_done", 8'(done_o), 8'd1);
        chk("rec_retry", 8'(retry_count_o), 8'd1);

        // illegal code during run
        tick(1, 0);
        for (int k = 1; k <= 4; k++) tick(0, 0);
        force_en = 1; force_val = 3'b011;
        tick(0, 0);
        chk("ill_illegal", 8'(illegal_o), 8'd1);
        chk("ill_fail", 8'(fail_o), 8'd1);
        force_en = 0;
        for (int k = 0; k < 4; k++) begin
            tick(0, 0);
            chk("ill_no_reset", 8'(fsm_reset_o), 8'd0);
        end
        tick(1, 0);
        chk("ill_clear_illegal", 8'(illegal_o), 8'd0);
        chk("ill_clear_fail", 8'(fail_o), 8'd0);
        for (int k = 1; k <= 6; k++) tick(0, 0);
        chk("ill_restart_done", 8'(done_o), 8'd1);

        // backward step STRT->INIT in done
        force_en = 1; force_val = INIT_C;
        tick(0, 0);
        force_en = 0;
        chk("bwd_illegal", 8'(illegal_o), 8'd1);
        chk("bwd_fail", 8'(fail_o), 8'd1);
        chk("bwd_done", 8'(done_o), 8'd0);

        // abort during run, with start on the same edge
        tick(1, 0);
        for (int k = 1; k <= 4; k++) tick(0, 0);
        tick(1, 1);
        chk("abt_pulse", 8'(fsm_reset_o), 8'd1);
        chk("abt_busy", 8'(busy_o), 8'd0);
        tick(0, 0);
        chk("abt_pulse_end", 8'(fsm_reset_o), 8'd0);
        chk("abt_start_ignored", 8'(busy_o), 8'd0);
        tick(1, 0);
        for (int k = 1; k <= 5; k++) tick(0, 0);
        chk("abt_done_e5", 8'(done_o), 8'd0);
        tick(0, 0);
        chk("abt_done_e6", 8'(done_o), 8'd1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit st, ab;
            st = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 149) == 0) stuck = ~stuck;
            if (force_en) force_en = 0;
            else if ($urandom_range(0, 49) == 0) begin
                force_en = 1;
                force_val = 3'($urandom_range(0, 7));
            end
            tick(st, ab);
        end
        force_en = 0;
        tick(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
